rv_div: RTL and testbench



---
 rtl/rv_pkg.sv | 17 +
 rtl/rv_addsub.sv | 13 +
 rtl/rv_div.sv | 146 ++++++++++++++
 tb/tb_rv_div.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage types: divider op encoding and divider FSM states.
package rv_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/rv_addsub.sv
// Parametrised adder/subtractor; subtraction is a + ~b + 1.
module rv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);

  assign y = a + (b ^ {WIDTH{sub}}) + {{(WIDTH-1){1'b0}}, sub};

endmodule

// File: rtl/rv_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve in a single cycle.
module rv_div
  import rv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  div_op_e         op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  div_op_e          op_q, op_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            accept, in_signed, in_is_rem, div_zero, sgn_ovf;
  logic [XLEN-1:0] neg_a, neg_b, abs_a, abs_b;
  logic [XLEN:0]   rem_sh, trial;
  logic            trial_ok;
  logic [XLEN-1:0] rem_step, quo_step, sel_val, sel_neg, fin_val;
  logic            q_is_rem, sel_negate;

  assign accept    = in_valid && (state_q == ST_IDLE) && !kill;
  assign in_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign in_is_rem = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  assign div_zero  = (op_b == '0);
  assign sgn_ovf   = in_signed && (op_a == MIN_VAL) && (op_b == '1);

  rv_addsub #(.WIDTH(XLEN)) u_neg_a (.a('0), .b(op_a), .sub(1'b1), .y(neg_a));
  rv_addsub #(.WIDTH(XLEN)) u_neg_b (.a('0), .b(op_b), .sub(1'b1), .y(neg_b));
  assign abs_a = op_a[XLEN-1] ? neg_a : op_a;
  assign abs_b = op_b[XLEN-1] ? neg_b : op_b;

  // Trial subtract is one bit wider so its MSB is the borrow.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  rv_addsub #(.WIDTH(XLEN+1)) u_trial (.a(rem_sh), .b({1'b0, dvs_q}), .sub(1'b1), .y(trial));
  assign trial_ok = !trial[XLEN];
  assign rem_step = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], trial_ok};

  // Only the selected result is ever negated, so one negator serves both.
  assign q_is_rem   = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);
  assign sel_val    = q_is_rem ? rem_step : quo_step;
  assign sel_negate = q_is_rem ? neg_rem_q : neg_quo_q;
  rv_addsub #(.WIDTH(XLEN)) u_neg_res (.a('0), .b(sel_val), .sub(1'b1), .y(sel_neg));
  assign fin_val = sel_negate ? sel_neg : sel_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) state_d = (div_zero || sgn_ovf) ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    res       = res_q;
  end

  always_comb begin
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    if (accept) begin
      op_d      = op;
      neg_quo_d = in_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
      neg_rem_d = in_signed && op_a[XLEN-1];
      quo_d     = in_signed ? abs_a : op_a;
      dvs_d     = in_signed ? abs_b : op_b;
      rem_d     = '0;
      cnt_d     = CNT_W'(XLEN);
      if (div_zero) begin
        res_d = in_is_rem ? op_a : '1;
      end else if (sgn_ovf) begin
        res_d = in_is_rem ? '0 : op_a;
      end
    end else if ((state_q == ST_CALC) && !kill) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) res_d = fin_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= DIV_OP_DIV;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
    end else begin
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rv_div.sv
// Directed and swept checks of rv_div at XLEN=32 and XLEN=8.
module tb_rv_div;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        kill = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel8 = 1'b0;
  div_op_e     op = DIV_OP_DIV;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic        ir32, ov32, ir8, ov8;
  logic [31:0] res32;
  logic [7:0]  res8;
  logic        cur_ir, cur_ov;
  logic [31:0] cur_res;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv_div #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel8), .in_ready(ir32),
    .op(op), .op_a(a_in), .op_b(b_in), .kill(kill),
    .out_valid(ov32), .out_ready(out_ready), .res(res32)
  );

  rv_div #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel8), .in_ready(ir8),
    .op(op), .op_a(a_in[7:0]), .op_b(b_in[7:0]), .kill(kill),
    .out_valid(ov8), .out_ready(out_ready), .res(res8)
  );

  assign cur_ir  = sel8 ? ir8 : ir32;
  assign cur_ov  = sel8 ? ov8 : ov32;
  assign cur_res = sel8 ? {24'd0, res8} : res32;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input div_op_e o, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    longint m, ua, ub, sa, sb, q, r, mn;
    bit is_sgn, is_rem;
    m  = (longint'(1) << w) - 1;
    mn = -((m + 1) >>> 1);
    ua = longint'({32'd0, a}) & m;
    ub = longint'({32'd0, b}) & m;
    sa = ((ua >> (w - 1)) != 0) ? ua - (m + 1) : ua;
    sb = ((ub >> (w - 1)) != 0) ? ub - (m + 1) : ub;
    is_sgn = (o == DIV_OP_DIV) || (o == DIV_OP_REM);
    is_rem = (o == DIV_OP_REM) || (o == DIV_OP_REMU);
    if (ub == 0) begin
      q = m; r = ua;
    end else if (is_sgn && sa == mn && sb == -1) begin
      q = ua; r = 0;
    end else if (is_sgn) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = ua / ub; r = ua % ub;
    end
    return is_rem ? 32'(r & m) : 32'(q & m);
  endfunction

  // Issue one request, wait for its result, check result, latency and in_ready during CALC.
  // Returns at the negedge where out_valid is first seen.
  task automatic do_req(input string tag, input div_op_e o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int guard;
    int lat;
    logic saw_ready;
    guard = 0;
    @(negedge clk);
    while (!cur_ir && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, {31'd0, cur_ir}, 32'd1);
    in_valid = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    saw_ready = 1'b0;
    while (!cur_ov && lat < 200) begin
      if (cur_ir) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, {31'd0, cur_ov}, 32'd1);
    check({tag, "_res"}, cur_res, exp_res);
    check({tag, "_busy"}, {31'd0, saw_ready}, 32'd0);
    if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
    $display("req %s op=%s a=%h b=%h res=%h lat=%0d", tag, o.name(), a, b, cur_res, lat);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] edges32 [4];
    logic [31:0] edges8 [4];
    edges32 = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
    edges8  = '{32'h0, 32'h1, 32'hFF, 32'h80};

    #12;
    check("rst_ready", {31'd0, ir32}, 32'd1);
    check("rst_valid", {31'd0, ov32}, 32'd0);
    check("rst_res", res32, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req("divu", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    do_req("remu", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    do_req("div_neg", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_req("rem_neg", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_req("div_mix", DIV_OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    do_req("divu_z", DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_req("rem_z", DIV_OP_REM, 32'd5, 32'd0, 32'd5, 1);
    do_req("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_req("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    do_req("divu_min", DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // Back-pressure: result must hold while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    do_req("hold", DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100, 33);
    held = res32;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, ov32}, 32'd1);
      check("hold_res", res32, held);
      check("hold_ready", {31'd0, ir32}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hs_ready", {31'd0, ir32}, 32'd1);
    check("hs_valid", {31'd0, ov32}, 32'd0);
    do_req("after_hold", DIV_OP_REMU, 32'd1001, 32'd10, 32'd1, 33);

    // Kill mid-CALC at t+10.
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; op = DIV_OP_DIVU; a_in = 32'd500; b_in = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_ready", {31'd0, ir32}, 32'd1);
    check("kill_valid", {31'd0, ov32}, 32'd0);
    do_req("after_kill", DIV_OP_DIVU, 32'd500, 32'd3, 32'd166, 33);

    // Kill while idle blocks a simultaneous request.
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; op = DIV_OP_DIVU; a_in = 32'd9; b_in = 32'd0;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    check("kill_noacc_ready", {31'd0, ir32}, 32'd1);
    check("kill_noacc_valid", {31'd0, ov32}, 32'd0);

    // Asynchronous reset mid-CALC at t+20.
    in_valid = 1'b1; op = DIV_OP_DIVU; a_in = 32'd1000; b_in = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, ir32}, 32'd1);
    check("arst_valid", {31'd0, ov32}, 32'd0);
    check("arst_res", res32, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req("after_rst", DIV_OP_REMU, 32'd1000, 32'd3, 32'd1, 33);

    // Swept operands, including 0, 1, -1 and MIN.
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      sel8 = (w == 0);
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a, b, msk;
        div_op_e o;
        msk = sel8 ? 32'hFF : 32'hFFFF_FFFF;
        a = ($urandom_range(0, 2) == 0) ? (sel8 ? edges8[$urandom_range(0, 3)]
                                                : edges32[$urandom_range(0, 3)])
                                        : ($urandom() & msk);
        b = ($urandom_range(0, 2) == 0) ? (sel8 ? edges8[$urandom_range(0, 3)]
                                                : edges32[$urandom_range(0, 3)])
                                        : ($urandom() & msk);
        o = div_op_e'($urandom_range(0, 3));
        do_req(sel8 ? "sweep8" : "sweep32", o, a, b, ref_model(o, a, b, sel8 ? 8 : 32), -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
